mac_array_os: RTL and testbench
===============================

# mac_array_os

Parametrised output-stationary successor to the weight-stationary MAC array. Each of ROW×COL PEs keeps its own partial sum while activations stream east and weights stream south. An instruction token rides diagonally with the data, so the feeder only needs to skew operands. Finished tiles are drained south through the psum registers, one row per cycle, into the output SRAM/OFIFO path.

## Interface
- BW, 4: signed activation/weight width
- PSUM_BW, 16: signed partial-sum width (≥ 2*BW)
- ROW, 8: PE rows
- COL, 8: PE columns

- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_w  in  ROW*BW  activations; lane r feeds PE(r,0)
- in_n  in  COL*BW  weights; lane c feeds PE(0,c)
- inst_w  in  2  [0]=acc, [1]=clr (valid only with acc); enters PE(0,0)
- drain  in  1  global, unskewed psum shift-south command
- out_s  out  COL*PSUM_BW  bottom-row psums, lane c = column c
- valid  out  COL  per-column out_s qualifier
- busy  out  1  any acc token in flight inside the array

## Operation
- PE(r,c) registers: a_reg (BW), w_reg (BW), inst_reg (2), psum (PSUM_BW).
- Data flow each edge: a_reg <= a from west (in_w[r] when c=0); w_reg <= w from north (in_n[c] when r=0).
- Token flow: inst_reg <= west neighbour's inst_reg for c>0. For c=0 it takes PE(r-1,0).inst_reg, and inst_w at r=0. PE(r,c) therefore sees a token r+c cycles after issue.
- Compute uses the incoming a, w and inst, not the registered copies:
  - inst[0]=1, inst[1]=0: psum <= psum + a*w
  - inst[0]=1, inst[1]=1: psum <= a*w (start of new tile, no clear pass needed)
  - inst[0]=0: psum holds
- Feeder contract for term k issued at cycle t:
  - inst_w at t
  - in_w[r] at t+r
  - in_n[c] at t+c
- Arithmetic: a*w is a signed 2*BW product, sign-extended to PSUM_BW, two's-complement add. Wraps unless saturation is compiled in (see Configuration).
- Drain, edge with drain=1:
  - out_s lane c <= psum(ROW-1,c)
  - psum(r,c) <= psum(r-1,c) for r>0
  - psum(0,c) <= 0
  - valid <= all ones
- Drain, edge with drain=0: valid <= 0 and out_s holds.
- ROW consecutive drain cycles emit rows bottom-first and leave the array all-zero.
- Drain and acc at the same PE on the same edge: drain wins for psum. The acc term is lost, while a/w/inst still advance. Drain while busy=1 is legal but corrupts the in-flight tile; the feeder must wait for busy=0.
- busy = OR of inst_reg[0] across all PEs (combinational from registers).

## Timing
- Reset (async on reset_n low) clears all a_reg, w_reg, inst_reg, psum, out_s and valid to 0. busy=0.
- Reset mid-drain or mid-compute: everything is zero immediately. Drain afterwards emits zeros.
- Last term issued at cycle t has landed in every PE after edge t+ROW+COL-2. busy falls at t+ROW+COL-1, so drain may start that cycle.
- Drain latency: out_s/valid update on the same edge drain is sampled (1 register stage). Row ROW-1-j appears after the (j+1)th drain edge.
- Back-to-back tiles: a clr token may issue the cycle after the last acc of the previous tile, but only after that tile has been fully drained.

## Configuration
- MAC_ARRAY_OS_SAT_EN defined: each accumulate saturates to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1]. The clr/overwrite product is already in range.
- Not defined: plain wrap-around add, no saturation logic.

## Test plan
- Reset: hold reset_n=0 with random inputs. Expect out_s=0, valid=0, busy=0. Release, then 8 drain cycles: expect 8 rows of zeros with valid=8'hFF.
- Single term: a=3 on all rows, w=2 on all cols, inst_w=2'b11 once, correctly skewed. Wait 15 cycles until busy=0, then drain 8 cycles. Expect every lane = 6 on each valid cycle.
- Signed accumulate: 4 terms a=-8, w=7 (first with clr). Expect every psum = -224 on drain.
- Clr mid-stream: three acc terms 1*1, then clr term 2*2, then acc 1*1. Expect 5 in every PE.
- Saturation, PSUM_BW=8: three terms a=-8, w=-8. Expect 127 with MAC_ARRAY_OS_SAT_EN and -64 (wrapped 192) without.
- Reset mid-drain: after 3 of 8 drain cycles, pulse reset_n low. Expect out_s and valid to go to 0 asynchronously; the remaining 5 drains return 0.

Source files
------------

// File: rtl/mac_array_os_if.sv
// Feeder/drain bundle for mac_array_os: skewed operands and tokens in, bottom-row psums out.
interface mac_array_os_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8
);
    logic [ROW*BW-1:0]      in_w;
    logic [COL*BW-1:0]      in_n;
    logic [1:0]             inst_w;
    logic                   drain;
    logic [COL*PSUM_BW-1:0] out_s;
    logic [COL-1:0]         valid;
    logic                   busy;

    modport master (output in_w, in_n, inst_w, drain, input  out_s, valid, busy);
    modport slave  (input  in_w, in_n, inst_w, drain, output out_s, valid, busy);
endinterface

// File: rtl/mac_array_os.sv
// Output-stationary ROWxCOL MAC array; acc/clr tokens ride diagonally, finished tiles drain south.
// Define MAC_ARRAY_OS_SAT_EN to saturate accumulates instead of wrapping.
module mac_array_os #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    mac_array_os_if.slave io_bus
);
    logic signed [BW-1:0]      r_a        [ROW][COL];
    logic signed [BW-1:0]      r_w        [ROW][COL];
    logic        [1:0]         r_inst     [ROW][COL];
    logic signed [PSUM_BW-1:0] r_psum     [ROW][COL];
    logic [COL*PSUM_BW-1:0]    r_out;
    logic [COL-1:0]            r_valid;

    logic signed [BW-1:0]      w_a_in     [ROW][COL];
    logic signed [BW-1:0]      w_w_in     [ROW][COL];
    logic        [1:0]         w_inst_in  [ROW][COL];
    logic signed [PSUM_BW-1:0] w_psum_nxt [ROW][COL];
    logic                      w_busy;

`ifdef MAC_ARRAY_OS_SAT_EN
    localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};
`endif

    for (genvar r = 0; r < ROW; r++) begin : g_row
        for (genvar c = 0; c < COL; c++) begin : g_col
            logic signed [2*BW-1:0]    w_prod;
            logic signed [PSUM_BW-1:0] w_ext;
            logic signed [PSUM_BW-1:0] w_acc;
            logic signed [PSUM_BW-1:0] w_mac;
            logic signed [PSUM_BW-1:0] w_north;

            if (c == 0) begin : g_west_edge
                assign w_a_in[r][c] = io_bus.in_w[r*BW +: BW];
            end else begin : g_west_pe
                assign w_a_in[r][c] = r_a[r][c-1];
            end

            if (r == 0) begin : g_north_edge
                assign w_w_in[r][c] = io_bus.in_n[c*BW +: BW];
                assign w_north      = '0;
            end else begin : g_north_pe
                assign w_w_in[r][c] = r_w[r-1][c];
                assign w_north      = r_psum[r-1][c];
            end

            // Column 0 threads the token down the rows; all other columns take it from the west.
            if (c != 0) begin : g_tok_west
                assign w_inst_in[r][c] = r_inst[r][c-1];
            end else if (r != 0) begin : g_tok_north
                assign w_inst_in[r][c] = r_inst[r-1][0];
            end else begin : g_tok_src
                assign w_inst_in[r][c] = io_bus.inst_w;
            end

            assign w_prod = w_a_in[r][c] * w_w_in[r][c];
            assign w_ext  = PSUM_BW'(w_prod);

`ifdef MAC_ARRAY_OS_SAT_EN
            logic signed [PSUM_BW:0] w_sum;
            assign w_sum = (PSUM_BW+1)'(r_psum[r][c]) + (PSUM_BW+1)'(w_ext);
            assign w_acc = (w_sum[PSUM_BW] == w_sum[PSUM_BW-1]) ? w_sum[PSUM_BW-1:0]
                         : (w_sum[PSUM_BW] ? PSUM_MIN : PSUM_MAX);
`else
            assign w_acc = r_psum[r][c] + w_ext;
`endif

            assign w_mac = w_inst_in[r][c][1] ? w_ext : w_acc;
            // Drain overrides any accumulate landing on the same edge.
            assign w_psum_nxt[r][c] = io_bus.drain      ? w_north
                                    : w_inst_in[r][c][0] ? w_mac
                                    : r_psum[r][c];
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int unsigned r = 0; r < ROW; r++) begin
            for (int unsigned c = 0; c < COL; c++) begin
                w_busy = w_busy | r_inst[r][c][0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a     <= '{default: '0};
            r_w     <= '{default: '0};
            r_inst  <= '{default: '0};
            r_psum  <= '{default: '0};
            r_out   <= '0;
            r_valid <= '0;
        end else begin
            r_a    <= w_a_in;
            r_w    <= w_w_in;
            r_inst <= w_inst_in;
            r_psum <= w_psum_nxt;
            if (io_bus.drain) begin
                r_valid <= '1;
                for (int unsigned c = 0; c < COL; c++) begin
                    r_out[c*PSUM_BW +: PSUM_BW] <= r_psum[ROW-1][c];
                end
            end else begin
                r_valid <= '0;
            end
        end
    end

    assign io_bus.out_s = r_out;
    assign io_bus.valid = r_valid;
    assign io_bus.busy  = w_busy;
endmodule

// File: tb/tb_mac_array_os.sv
// Self-checking bench for mac_array_os: 16-bit and 8-bit psum instances fed identical skewed stimulus,
// checked against a tile-level arithmetic model (honours MAC_ARRAY_OS_SAT_EN).
module tb_mac_array_os;
    localparam int BW       = 4;
    localparam int PSUM_BW  = 16;
    localparam int PSUM_BW8 = 8;
    localparam int ROW      = 8;
    localparam int COL      = 8;
    localparam int MAXT     = 8;

    typedef struct {
        int         nt;
        int         a    [5];
        int         w    [5];
        logic [1:0] inst [5];
        int         e16;
        int         e8;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    int         m16 [ROW][COL];
    int         m8  [ROW][COL];
    int         ta  [MAXT][ROW];
    int         tw  [MAXT][COL];
    logic [1:0] ti  [MAXT];
    int         nt;
    vec_t       tbl [4];

    always #5 clk = ~clk;

    mac_array_os_if #(.BW(BW), .PSUM_BW(PSUM_BW),  .ROW(ROW), .COL(COL)) bus16 ();
    mac_array_os_if #(.BW(BW), .PSUM_BW(PSUM_BW8), .ROW(ROW), .COL(COL)) bus8 ();

    mac_array_os #(.BW(BW), .PSUM_BW(PSUM_BW),  .ROW(ROW), .COL(COL)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .io_bus(bus16));
    mac_array_os #(.BW(BW), .PSUM_BW(PSUM_BW8), .ROW(ROW), .COL(COL)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .io_bus(bus8));

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [ROW*BW-1:0] iw, input logic [COL*BW-1:0] inn,
                         input logic [1:0] inst, input logic d);
        bus16.in_w = iw;  bus16.in_n = inn;  bus16.inst_w = inst;  bus16.drain = d;
        bus8.in_w  = iw;  bus8.in_n  = inn;  bus8.inst_w  = inst;  bus8.drain  = d;
    endtask

    function automatic int fix(input int v, input int bw);
        int lo, hi, m;
        lo = -(1 << (bw - 1));
        hi = (1 << (bw - 1)) - 1;
`ifdef MAC_ARRAY_OS_SAT_EN
        m = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        m = v & ((1 << bw) - 1);
        if (m > hi) m = m - (1 << bw);
`endif
        return m;
    endfunction

    task automatic zero_model();
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                m16[r][c] = 0;
                m8[r][c]  = 0;
            end
    endtask

    task automatic apply_model();
        int p;
        for (int k = 0; k < nt; k++) begin
            if (ti[k][0]) begin
                for (int r = 0; r < ROW; r++)
                    for (int c = 0; c < COL; c++) begin
                        p = ta[k][r] * tw[k][c];
                        if (ti[k][1]) begin
                            m16[r][c] = p;
                            m8[r][c]  = p;
                        end else begin
                            m16[r][c] = fix(m16[r][c] + p, PSUM_BW);
                            m8[r][c]  = fix(m8[r][c] + p, PSUM_BW8);
                        end
                    end
            end
        end
    endtask

    // Skewed feeder: term k -> inst at k, row r at k+r, column c at k+c; junk everywhere else.
    task automatic issue();
        logic [ROW*BW-1:0] iw;
        logic [COL*BW-1:0] inn;
        logic [1:0]        inst;
        int                idx;
        for (int k = 0; k < nt + ROW + COL; k++) begin
            @(negedge clk);
            if (k == 1 && ti[0][0])
                check("busy_rise", 128'(bus16.busy & bus8.busy), 128'(1));
            iw  = (ROW*BW)'($urandom);
            inn = (COL*BW)'($urandom);
            for (int r = 0; r < ROW; r++) begin
                idx = k - r;
                if (idx >= 0 && idx < nt) iw[r*BW +: BW] = BW'(ta[idx][r]);
            end
            for (int c = 0; c < COL; c++) begin
                idx = k - c;
                if (idx >= 0 && idx < nt) inn[c*BW +: BW] = BW'(tw[idx][c]);
            end
            inst = (k < nt) ? ti[k] : 2'b00;
            drive(iw, inn, inst, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((bus16.busy !== 1'b0 || bus8.busy !== 1'b0) && i < 40) begin
            @(negedge clk);
            i++;
        end
        check("busy_fall", 128'({bus16.busy, bus8.busy}), 128'(0));
    endtask

    task automatic drain_rows(input string nm, input int n, input bit use_const,
                              input int c16, input int c8);
        logic [127:0] e16, e8;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            drive((ROW*BW)'($urandom), (COL*BW)'($urandom), 2'b00, 1'b1);
            @(posedge clk);
            #1;
            e16 = '0;
            e8  = '0;
            for (int c = 0; c < COL; c++) begin
                e16[c*PSUM_BW  +: PSUM_BW]  = PSUM_BW'(use_const ? c16 : m16[ROW-1][c]);
                e8[c*PSUM_BW8 +: PSUM_BW8]  = PSUM_BW8'(use_const ? c8 : m8[ROW-1][c]);
            end
            for (int c = 0; c < COL; c++) begin
                for (int r = ROW - 1; r > 0; r--) begin
                    m16[r][c] = m16[r-1][c];
                    m8[r][c]  = m8[r-1][c];
                end
                m16[0][c] = 0;
                m8[0][c]  = 0;
            end
            check($sformatf("%s_row%0d_out16", nm, j), 128'(bus16.out_s), e16);
            check($sformatf("%s_row%0d_out8", nm, j),  128'(bus8.out_s),  e8);
            check($sformatf("%s_row%0d_valid", nm, j), 128'({bus16.valid, bus8.valid}), 128'(16'hFFFF));
        end
    endtask

    task automatic drain_stop(input string nm);
        @(negedge clk);
        drive((ROW*BW)'($urandom), (COL*BW)'($urandom), 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check({nm, "_valid_drop"}, 128'({bus16.valid, bus8.valid}), 128'(0));
    endtask

    task automatic random_tile(input int n);
        int pick;
        nt = n;
        for (int k = 0; k < nt; k++) begin
            for (int r = 0; r < ROW; r++) ta[k][r] = int'($urandom_range(0, 15)) - 8;
            for (int c = 0; c < COL; c++) tw[k][c] = int'($urandom_range(0, 15)) - 8;
            pick  = int'($urandom_range(0, 3));
            ti[k] = (k == 0 || pick == 3) ? 2'b11 : (pick == 0 ? 2'b00 : 2'b01);
        end
    endtask

    initial begin
        tbl[0].nt = 1; tbl[0].a = '{3, 0, 0, 0, 0}; tbl[0].w = '{2, 0, 0, 0, 0};
        tbl[0].inst = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00}; tbl[0].e16 = 6; tbl[0].e8 = 6;
        tbl[1].nt = 4; tbl[1].a = '{-8, -8, -8, -8, 0}; tbl[1].w = '{7, 7, 7, 7, 0};
        tbl[1].inst = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00}; tbl[1].e16 = -224;
        tbl[2].nt = 5; tbl[2].a = '{1, 1, 1, 2, 1}; tbl[2].w = '{1, 1, 1, 2, 1};
        tbl[2].inst = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01}; tbl[2].e16 = 5; tbl[2].e8 = 5;
        tbl[3].nt = 3; tbl[3].a = '{-8, -8, -8, 0, 0}; tbl[3].w = '{-8, -8, -8, 0, 0};
        tbl[3].inst = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00}; tbl[3].e16 = 192;
`ifdef MAC_ARRAY_OS_SAT_EN
        tbl[1].e8 = -128;
        tbl[3].e8 = 127;
`else
        tbl[1].e8 = 32;
        tbl[3].e8 = -64;
`endif

        drive('0, '0, 2'b00, 1'b0);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive((ROW*BW)'($urandom), (COL*BW)'($urandom), 2'($urandom), 1'($urandom));
            #1;
            check($sformatf("rst%0d_out", i), {bus16.out_s, bus8.out_s[63:0]}, 128'(0));
            check($sformatf("rst%0d_vb", i), 128'({bus16.valid, bus8.valid, bus16.busy, bus8.busy}), 128'(0));
        end
        @(negedge clk);
        drive('0, '0, 2'b00, 1'b0);
        reset_n = 1'b1;
        zero_model();
        drain_rows("rst_drain", ROW, 1'b0, 0, 0);
        drain_stop("rst_drain");

        for (int t = 0; t < 4; t++) begin
            nt = tbl[t].nt;
            for (int k = 0; k < nt; k++) begin
                for (int r = 0; r < ROW; r++) ta[k][r] = tbl[t].a[k];
                for (int c = 0; c < COL; c++) tw[k][c] = tbl[t].w[k];
                ti[k] = tbl[t].inst[k];
            end
            apply_model();
            issue();
            wait_idle();
            drain_rows($sformatf("vec%0d", t), ROW, 1'b1, tbl[t].e16, tbl[t].e8);
            drain_stop($sformatf("vec%0d", t));
        end

        for (int t = 0; t < 6; t++) begin
            random_tile(int'($urandom_range(1, 6)));
            apply_model();
            issue();
            wait_idle();
            drain_rows($sformatf("rand%0d", t), ROW, 1'b0, 0, 0);
            drain_stop($sformatf("rand%0d", t));
        end

        // Reset lands between edges while drain is still asserted.
        random_tile(3);
        apply_model();
        issue();
        wait_idle();
        drain_rows("pre_rst", 3, 1'b0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_out", {bus16.out_s, bus8.out_s[63:0]}, 128'(0));
        check("midrst_vb", 128'({bus16.valid, bus8.valid, bus16.busy, bus8.busy}), 128'(0));
        zero_model();
        @(negedge clk);
        reset_n = 1'b1;
        drain_rows("post_rst", 5, 1'b0, 0, 0);
        drain_stop("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
